// File: rtl/readout_sequencer.sv
// Per-shot readout controller: trigger -> delay -> collection window -> wait for I/Q -> hold for handshake.
// Optional result timeout in WAIT_RESULT is enabled by defining READOUT_TIMEOUT_EN.
module readout_sequencer #(
  parameter int SHOT_W         = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DELAY_RST      = 5000,
  parameter int LENGTH_RST     = 2000
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              trigger,
  input  logic              cfg_update,
  input  logic [13:0]       delay_time_new,
  input  logic [10:0]       sample_length_new,
  input  logic              iq_valid_in,
  input  logic [31:0]       i_val_in,
  input  logic [31:0]       q_val_in,
  input  logic              res_ready,
  output logic [13:0]       delay_time,
  output logic [10:0]       sample_length,
  output logic              start_collect,
  output logic              collect_active,
  output logic              busy,
  output logic              res_valid,
  output logic [31:0]       res_i,
  output logic [31:0]       res_q,
  output logic [SHOT_W-1:0] res_shot,
  output logic              trig_overrun,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_COLLECT = 3'd2,
    S_WAIT    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [13:0]         r_cnt, w_cnt_nxt;
  logic [13:0]         r_delay_time, w_delay_nxt;
  logic [10:0]         r_sample_length, w_len_nxt;
  logic                r_pend_vld, w_pend_vld_nxt;
  logic [13:0]         r_pend_delay, w_pend_delay_nxt;
  logic [10:0]         r_pend_len, w_pend_len_nxt;
  logic [SHOT_W-1:0]   r_shot_cnt, w_shot_nxt;
  logic [31:0]         r_res_i, w_res_i_nxt;
  logic [31:0]         r_res_q, w_res_q_nxt;
  logic [SHOT_W-1:0]   r_res_shot, w_res_shot_nxt;
  logic                r_res_valid, w_res_valid_nxt;
  logic                r_start_collect, w_start_nxt;
  logic                r_collect_active, w_active_nxt;
  logic                r_busy;
  logic                r_trig_d;
  logic                r_trig_overrun, w_ovr_nxt;
  logic                w_capture;
  logic                w_go_idle;
  logic [13:0]         w_coll_load;
`ifdef READOUT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
  logic                r_timeout_err, w_timeout_nxt;
`endif

  // Collection runs max(sample_length,1) cycles: load length-1, leave COLLECT when it reaches 0.
  assign w_coll_load = (r_sample_length == 11'd0) ? 14'd0 : {3'b000, r_sample_length - 11'd1};
  assign w_ovr_nxt   = trigger & ~r_trig_d & (r_state != S_IDLE);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_delay_nxt      = r_delay_time;
    w_len_nxt        = r_sample_length;
    w_pend_vld_nxt   = r_pend_vld;
    w_pend_delay_nxt = r_pend_delay;
    w_pend_len_nxt   = r_pend_len;
    w_shot_nxt       = r_shot_cnt;
    w_res_i_nxt      = r_res_i;
    w_res_q_nxt      = r_res_q;
    w_res_shot_nxt   = r_res_shot;
    w_res_valid_nxt  = r_res_valid;
    w_start_nxt      = 1'b0;
    w_active_nxt     = 1'b0;
    w_capture        = 1'b0;
    w_go_idle        = 1'b0;
`ifdef READOUT_TIMEOUT_EN
    w_to_cnt_nxt     = r_to_cnt;
    w_timeout_nxt    = r_timeout_err;
`endif

    // Live values only move while idle; mid-shot updates park in the pending slot.
    if (cfg_update) begin
      if (r_state == S_IDLE) begin
        w_delay_nxt = delay_time_new;
        w_len_nxt   = sample_length_new;
      end else begin
        w_pend_vld_nxt   = 1'b1;
        w_pend_delay_nxt = delay_time_new;
        w_pend_len_nxt   = sample_length_new;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (trigger) begin
          w_state_nxt = S_DELAY;
          w_cnt_nxt   = cfg_update ? delay_time_new : r_delay_time;
        end
      end
      S_DELAY: begin
        if (r_cnt == 14'd0) begin
          w_state_nxt  = S_COLLECT;
          w_cnt_nxt    = w_coll_load;
          w_start_nxt  = 1'b1;
          w_active_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 14'd1;
        end
      end
      S_COLLECT: begin
        if (iq_valid_in) begin
          w_capture = 1'b1;
        end else if (r_cnt == 14'd0) begin
          w_state_nxt = S_WAIT;
`ifdef READOUT_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
        end else begin
          w_cnt_nxt    = r_cnt - 14'd1;
          w_active_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (iq_valid_in) begin
          w_capture = 1'b1;
`ifdef READOUT_TIMEOUT_EN
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_go_idle     = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
`endif
        end
      end
      S_HOLD: begin
        // Result port: res_valid stays high with res_* frozen until a cycle with res_ready=1.
        if (res_ready) begin
          w_go_idle       = 1'b1;
          w_res_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_capture) begin
      w_state_nxt     = S_HOLD;
      w_res_i_nxt     = i_val_in;
      w_res_q_nxt     = q_val_in;
      w_res_shot_nxt  = r_shot_cnt;
      w_shot_nxt      = r_shot_cnt + 1'b1;
      w_res_valid_nxt = 1'b1;
    end

    if (w_go_idle) begin
      w_state_nxt    = S_IDLE;
      w_pend_vld_nxt = 1'b0;
      if (cfg_update) begin
        w_delay_nxt = delay_time_new;
        w_len_nxt   = sample_length_new;
      end else if (r_pend_vld) begin
        w_delay_nxt = r_pend_delay;
        w_len_nxt   = r_pend_len;
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_delay_time     <= 14'(DELAY_RST);
      r_sample_length  <= 11'(LENGTH_RST);
      r_pend_vld       <= 1'b0;
      r_pend_delay     <= '0;
      r_pend_len       <= '0;
      r_shot_cnt       <= '0;
      r_res_i          <= '0;
      r_res_q          <= '0;
      r_res_shot       <= '0;
      r_res_valid      <= 1'b0;
      r_start_collect  <= 1'b0;
      r_collect_active <= 1'b0;
      r_busy           <= 1'b0;
      r_trig_d         <= 1'b0;
      r_trig_overrun   <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_delay_time     <= w_delay_nxt;
      r_sample_length  <= w_len_nxt;
      r_pend_vld       <= w_pend_vld_nxt;
      r_pend_delay     <= w_pend_delay_nxt;
      r_pend_len       <= w_pend_len_nxt;
      r_shot_cnt       <= w_shot_nxt;
      r_res_i          <= w_res_i_nxt;
      r_res_q          <= w_res_q_nxt;
      r_res_shot       <= w_res_shot_nxt;
      r_res_valid      <= w_res_valid_nxt;
      r_start_collect  <= w_start_nxt;
      r_collect_active <= w_active_nxt;
      r_busy           <= (w_state_nxt != S_IDLE);
      r_trig_d         <= trigger;
      r_trig_overrun   <= w_ovr_nxt;
    end
  end

`ifdef READOUT_TIMEOUT_EN
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_to_cnt      <= w_to_cnt_nxt;
      r_timeout_err <= w_timeout_nxt;
    end
  end
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign delay_time     = r_delay_time;
  assign sample_length  = r_sample_length;
  assign start_collect  = r_start_collect;
  assign collect_active = r_collect_active;
  assign busy           = r_busy;
  assign res_valid      = r_res_valid;
  assign res_i          = r_res_i;
  assign res_q          = r_res_q;
  assign res_shot       = r_res_shot;
  assign trig_overrun   = r_trig_overrun;

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: directed shots plus randomized shots checked against a cycle-count model.
module tb_readout_sequencer;

  localparam int SW        = 6;
  localparam int SHOTS_MOD = 1 << SW;

  logic          clk100 = 1'b0;
  logic          reset, trigger, cfg_update, iq_valid_in, res_ready;
  logic [13:0]   delay_time_new;
  logic [10:0]   sample_length_new;
  logic [31:0]   i_val_in, q_val_in;
  logic [13:0]   delay_time;
  logic [10:0]   sample_length;
  logic          start_collect, collect_active, busy, res_valid, trig_overrun, timeout_err;
  logic [31:0]   res_i, res_q;
  logic [SW-1:0] res_shot;

  always #5 clk100 = ~clk100;

  readout_sequencer #(.SHOT_W(SW)) dut (
    .clk100(clk100), .reset(reset), .trigger(trigger), .cfg_update(cfg_update),
    .delay_time_new(delay_time_new), .sample_length_new(sample_length_new),
    .iq_valid_in(iq_valid_in), .i_val_in(i_val_in), .q_val_in(q_val_in), .res_ready(res_ready),
    .delay_time(delay_time), .sample_length(sample_length), .start_collect(start_collect),
    .collect_active(collect_active), .busy(busy), .res_valid(res_valid), .res_i(res_i),
    .res_q(res_q), .res_shot(res_shot), .trig_overrun(trig_overrun), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;
  // Reference model: live/pending config, shot index, expected start pulses
  int m_delay = 5000, m_len = 2000, m_shot = 0, m_pd = 0, m_pl = 0, m_starts = 0;
  bit m_pend = 1'b0, m_tout = 1'b0;
  int n_start = 0;

  always @(posedge clk100) if (start_collect) n_start <= n_start + 1;

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cfg_mode: 0 none, 1 load while idle, 2 load with trigger, 3 load during COLLECT
  task automatic shot(input int cfg_mode, input int nd, input int nl, input int iq_wait,
                      input bit iq_in_coll, input int rdy_wait, input bit extra_trig,
                      input bit ign_iq, input logic [31:0] iv, input logic [31:0] qv);
    int exp_d, exp_l, n, c, rw;
    if (cfg_mode == 1) begin
      cfg_update = 1'b1; delay_time_new = 14'(nd); sample_length_new = 11'(nl);
      tick();
      cfg_update = 1'b0;
      m_delay = nd; m_len = nl;
    end
    trigger = 1'b1;
    if (cfg_mode == 2) begin
      cfg_update = 1'b1; delay_time_new = 14'(nd); sample_length_new = 11'(nl);
      m_delay = nd; m_len = nl;
    end
    exp_d = m_delay;
    exp_l = (m_len == 0) ? 1 : m_len;
    tick();
    trigger = 1'b0; cfg_update = 1'b0;
    chk("cfg_delay", delay_time, m_delay);
    chk("cfg_len", sample_length, m_len);
    chk("busy_on", busy, 1);
    n = 0;
    do begin
      if (n == 0 && ign_iq) iq_valid_in = 1'b1;
      tick();
      iq_valid_in = 1'b0;
      n++;
    end while (!start_collect && n < exp_d + 10);
    chk("start_seen", start_collect, 1);
    chk("start_lat", n, exp_d + 1);
    chk("no_res_in_delay", res_valid, 0);
    m_starts++;
    i_val_in = iv; q_val_in = qv;
    c = 0;
    while (collect_active && c < 3000) begin
      c++;
      if (cfg_mode == 3 && c == 1) begin
        cfg_update = 1'b1; delay_time_new = 14'(nd); sample_length_new = 11'(nl);
        m_pend = 1'b1; m_pd = nd; m_pl = nl;
      end
      if (iq_in_coll && c == 2) iq_valid_in = 1'b1;
      tick();
      cfg_update = 1'b0; iq_valid_in = 1'b0;
      if (c == 1) chk("start_pulse", start_collect, 0);
    end
    chk("collect_len", c, iq_in_coll ? 2 : exp_l);
    if (!iq_in_coll) begin
      for (int k = 0; k < iq_wait; k++) tick();
      chk("wait_busy", busy, 1);
      chk("wait_no_res", res_valid, 0);
      iq_valid_in = 1'b1;
      tick();
      iq_valid_in = 1'b0;
    end
    chk("res_valid", res_valid, 1);
    chk("res_i", res_i, iv);
    chk("res_q", res_q, qv);
    chk("res_shot", res_shot, m_shot);
    i_val_in = $urandom; q_val_in = $urandom;
    rw = (extra_trig && rdy_wait < 2) ? 2 : rdy_wait;
    for (int k = 0; k < rw; k++) begin
      if (extra_trig && k == 0) trigger = 1'b1;
      tick();
      trigger = 1'b0;
      if (extra_trig && k == 0) chk("overrun_pulse", trig_overrun, 1);
      if (extra_trig && k == 1) chk("overrun_once", trig_overrun, 0);
      chk("hold_valid", res_valid, 1);
      chk("hold_i", res_i, iv);
      chk("hold_q", res_q, qv);
      chk("hold_shot", res_shot, m_shot);
      chk("hold_no_start", start_collect, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("release_valid", res_valid, 0);
    chk("release_busy", busy, 0);
    chk("timeout_flag", timeout_err, m_tout);
    m_shot = (m_shot + 1) % SHOTS_MOD;
    if (m_pend) begin
      m_delay = m_pd; m_len = m_pl; m_pend = 1'b0;
    end
    chk("idle_delay", delay_time, m_delay);
    chk("idle_len", sample_length, m_len);
  endtask

  initial begin
    int n;
    reset = 1'b1; trigger = 1'b0; cfg_update = 1'b0; iq_valid_in = 1'b0; res_ready = 1'b0;
    delay_time_new = '0; sample_length_new = '0; i_val_in = '0; q_val_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_delay", delay_time, 5000);
    chk("rst_len", sample_length, 2000);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_start", start_collect, 0);
    chk("rst_active", collect_active, 0);
    chk("rst_overrun", trig_overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_shot", res_shot, 0);

    // Result strobe while idle must be ignored
    iq_valid_in = 1'b1; tick(); iq_valid_in = 1'b0;
    chk("idle_iq_valid", res_valid, 0);
    chk("idle_iq_busy", busy, 0);

    shot(1, 3, 4, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0010, 32'hFFFF_FFFB);
    shot(0, 0, 0, 2, 1'b0, 10, 1'b1, 1'b0, $urandom, $urandom);
    shot(3, 0, 2, 1, 1'b0, 0, 1'b0, 1'b0, $urandom, $urandom);
    shot(0, 0, 0, 0, 1'b0, 1, 1'b0, 1'b0, $urandom, $urandom);
    shot(2, 5, 0, 3, 1'b0, 2, 1'b0, 1'b1, $urandom, $urandom);
    shot(1, 2, 3, 0, 1'b1, 0, 1'b0, 1'b0, $urandom, $urandom);

`ifdef READOUT_TIMEOUT_EN
    cfg_update = 1'b1; delay_time_new = 14'd1; sample_length_new = 11'd2;
    tick();
    cfg_update = 1'b0; m_delay = 1; m_len = 2;
    trigger = 1'b1; tick(); trigger = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!start_collect && n < 20);
    chk("to_start", start_collect, 1);
    m_starts++;
    n = 0;
    while (collect_active && n < 50) begin tick(); n++; end
    chk("to_coll_done", collect_active, 0);
    n = 0;
    do begin tick(); n++; end while (busy && n < 300);
    chk("to_cycles", n, 64);
    chk("to_err", timeout_err, 1);
    chk("to_no_res", res_valid, 0);
    m_tout = 1'b1;
`else
    n = 0;
    shot(1, 1, 1, 100, 1'b0, 0, 1'b0, 1'b0, $urandom, $urandom);
    chk("no_timeout_flag", timeout_err, n);
`endif

    for (int s = 0; s < 70; s++) begin
      int mode, nd, nl, eff;
      bit coll;
      mode = $urandom_range(0, 3);
      nd   = $urandom_range(0, 6);
      nl   = $urandom_range(0, 5);
      eff  = (mode == 1 || mode == 2) ? nl : m_len;
      coll = (eff >= 2) && ($urandom_range(0, 2) == 0);
      shot(mode, nd, nl, $urandom_range(0, 4), coll, $urandom_range(0, 4),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
    end

    // Reset while counting the delay: shot aborted, no start pulse, pending config dropped
    cfg_update = 1'b1; delay_time_new = 14'd10; sample_length_new = 11'd3;
    tick();
    cfg_update = 1'b0; m_delay = 10; m_len = 3;
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (3) tick();
    chk("dly_busy", busy, 1);
    cfg_update = 1'b1; delay_time_new = 14'd7; sample_length_new = 11'd7;
    tick();
    cfg_update = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    m_delay = 5000; m_len = 2000; m_shot = 0; m_pend = 1'b0; m_tout = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_delay", delay_time, m_delay);
    chk("mid_rst_len", sample_length, m_len);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    repeat (20) tick();
    chk("mid_rst_no_start", n_start, m_starts);

    shot(1, 1, 2, 1, 1'b0, 1, 1'b0, 1'b0, $urandom, $urandom);
    chk("total_starts", n_start, m_starts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
